tlp_rw_demux: RTL and testbench
===============================

Name: tlp_rw_demux

Overview:
- Two-way packet demultiplexer on the PCIe receive path.
- Accepts a TLP stream (header, data, sop/eop, valid/ready) and decodes the header at the start-of-packet beat.
- Memory-read TLPs go to the read port; memory-write TLPs go to the write port; every other TLP is consumed and dropped.
- Each output has one registered stage, and outputs are independently back-pressured.

Parameters:
- PORTS, 2: number of output ports; fixed at 2 (read, write); any other value is unsupported.
- DOUBLE_WORD, 32: bits per PCIe DW.
- HEADER_SIZE, 128: header bus width (4 DW).
- TLP_DATA_WIDTH, 256: data beat width (8 DW).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted at 1, despite the name).
- in_data  in  TLP_DATA_WIDTH  input payload beat.
- in_hdr  in  HEADER_SIZE  input header; sampled only on sop beat.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- r_out_data  out  TLP_DATA_WIDTH  read-port payload.
- r_out_hdr, r_out_sop, r_out_eop, r_out_valid  out  HEADER_SIZE/1/1/1  read-port header, framing, valid.
- r_out_ready  in  1  read-port sink ready.
- w_out_data, w_out_hdr, w_out_sop, w_out_eop, w_out_valid  out  same widths  write-port equivalents.
- w_out_ready  in  1  write-port sink ready.
- enable  in  1  0 = stall input (in_ready=0); registered outputs still drain.

Behaviour:
- Decode uses header DW0: fmt = in_hdr[31:29], type = in_hdr[28:24].
  - READ if type==5'b00000 and fmt in {000,001}.
  - WRITE if type==5'b00000 and fmt in {010,011}.
  - Anything else is DROP.
- State machine IDLE/RD/WR/DROP, reset to IDLE.
  - Any accepted beat with in_sop=1 re-decodes the header and selects the destination, whatever the current state.
  - A sop beat received mid-packet starts a new packet; the old packet is left unterminated.
  - Accepted beat with in_eop=1 returns the FSM to IDLE.
  - Beat with sop&eop in one cycle: a one-beat packet, stays IDLE.
- Accepted non-sop beats in IDLE are dropped.
- Per-port output register is "free" when !x_out_valid || x_out_ready.
- in_ready = enable && free(dest), where dest is the decoded destination.
  - dest comes from the current in_hdr on a sop beat, otherwise from the state.
  - DROP destination is always free, so dropped TLPs are consumed at 1 beat/cycle.
- On an accepted beat to port x:
  - x_out_data/hdr/sop/eop load the input, and x_out_valid=1 on the next cycle (latency 1).
  - The header is forwarded unchanged on every beat of the packet.
- If x_out_valid && x_out_ready and no new load occurs, x_out_valid clears next cycle.
- Output data/hdr/sop/eop hold stable while x_out_valid && !x_out_ready.
- The two ports never load in the same cycle, but drain concurrently.
- A stalled port back-pressures input only while the input targets that port; it does not block traffic to the other port.
- Reset (rst_n=1, sync):
  - all *_out_valid=0 and *_out_sop/eop=0; *_out_data/hdr=0; FSM=IDLE.
  - in_ready=0 while reset is asserted.
- Reset mid-packet: the partial packet is discarded; outputs are cleared.
- enable=0 mid-packet: FSM state is held; resumes on enable=1.

Optional Feature:
- Macro TLP_DEMUX_DROP_CNT_EN.
  - Defined: adds output drop_cnt [15:0], a saturating count (stops at 16'hFFFF) of dropped packets. It increments once per accepted sop beat decoded as DROP, and is reset to 0.
  - Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- MRd 1-beat (hdr[31:24]=8'h00, sop=eop=1), r_out_ready=1 → r_out_valid=1 next cycle, r_out_hdr equals input, w_out_valid stays 0.
- MWr 3 beats (hdr[31:24]=8'h40, data 1,2,3), w_out_ready=1 → w port emits 1,2,3 on consecutive cycles, sop on beat 1, eop on beat 3.
- Illegal TLP (hdr[31:24]=8'h04, CfgRd) 2 beats → in_ready=1 both cycles, no output valid, drop_cnt=1 if TLP_DEMUX_DROP_CNT_EN.
- MRd with r_out_ready=0 for 10 cycles → first beat held on r_out, in_ready=0 for the next read beat, then exactly one transfer per r_out_ready cycle with no loss or duplication.
- Read port stalled while a MWr arrives → write beats accepted and emitted on w port.
- enable=0 with in_valid=1 → in_ready=0; rst_n=1 mid-packet → all out_valid=0 next cycle, FSM returns to IDLE.

Source files
------------

// File: rtl/tlp_rw_demux.sv
// Two-way TLP demultiplexer: memory reads to the r port, memory writes to the w port, all else dropped.
// Optional drop counter output enabled by defining TLP_DEMUX_DROP_CNT_EN.
module tlp_rw_demux #(
  parameter int PORTS          = 2,
  parameter int DOUBLE_WORD    = 32,
  parameter int HEADER_SIZE    = 128,
  parameter int TLP_DATA_WIDTH = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TLP_DATA_WIDTH-1:0] in_data,
  input  logic [HEADER_SIZE-1:0]    in_hdr,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [TLP_DATA_WIDTH-1:0] r_out_data,
  output logic [HEADER_SIZE-1:0]    r_out_hdr,
  output logic                      r_out_sop,
  output logic                      r_out_eop,
  output logic                      r_out_valid,
  input  logic                      r_out_ready,
  output logic [TLP_DATA_WIDTH-1:0] w_out_data,
  output logic [HEADER_SIZE-1:0]    w_out_hdr,
  output logic                      w_out_sop,
  output logic                      w_out_eop,
  output logic                      w_out_valid,
  input  logic                      w_out_ready,
`ifdef TLP_DEMUX_DROP_CNT_EN
  output logic [15:0]               drop_cnt,
`endif
  input  logic                      enable
);

  typedef enum logic [1:0] {IDLE, RD, WR, DROP} state_t;

  localparam int RD_IDX = 0;
  localparam int WR_IDX = 1;

  state_t             state, state_nxt;
  state_t             hdr_dest, dest;
  logic               r_free, w_free, accept;
  logic [PORTS-1:0]   load;

  // Destination from header DW0: fmt = [31:29], type = [28:24].
  function automatic state_t decode(input logic [HEADER_SIZE-1:0] hdr);
    logic [2:0] fmt;
    logic [4:0] typ;
    fmt = hdr[DOUBLE_WORD-1 -: 3];
    typ = hdr[DOUBLE_WORD-4 -: 5];
    if (typ == 5'b00000 && (fmt == 3'b000 || fmt == 3'b001))
      return RD;
    else if (typ == 5'b00000 && (fmt == 3'b010 || fmt == 3'b011))
      return WR;
    else
      return DROP;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    hdr_dest  = decode(in_hdr);
    dest      = in_sop ? hdr_dest : state;
    r_free    = !r_out_valid || r_out_ready;
    w_free    = !w_out_valid || w_out_ready;
    in_ready  = 1'b0;
    load      = '0;
    state_nxt = state;

    // IDLE as a destination means a stray non-sop beat: consume it like DROP.
    case (dest)
      RD:      in_ready = !rst_n && enable && r_free;
      WR:      in_ready = !rst_n && enable && w_free;
      default: in_ready = !rst_n && enable;
    endcase

    accept       = in_valid && in_ready;
    load[RD_IDX] = accept && (dest == RD);
    load[WR_IDX] = accept && (dest == WR);

    if (accept) begin
      if (in_eop)
        state_nxt = IDLE;
      else if (in_sop)
        state_nxt = hdr_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Output stage: one register per port, loaded on accept, cleared on drain.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_data  <= '0;
      r_out_hdr   <= '0;
    end else if (load[RD_IDX]) begin
      r_out_valid <= 1'b1;
      r_out_sop   <= in_sop;
      r_out_eop   <= in_eop;
      r_out_data  <= in_data;
      r_out_hdr   <= in_hdr;
    end else if (r_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      w_out_valid <= 1'b0;
      w_out_sop   <= 1'b0;
      w_out_eop   <= 1'b0;
      w_out_data  <= '0;
      w_out_hdr   <= '0;
    end else if (load[WR_IDX]) begin
      w_out_valid <= 1'b1;
      w_out_sop   <= in_sop;
      w_out_eop   <= in_eop;
      w_out_data  <= in_data;
      w_out_hdr   <= in_hdr;
    end else if (w_out_ready) begin
      w_out_valid <= 1'b0;
    end
  end

`ifdef TLP_DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_n)
      drop_cnt <= '0;
    else if (accept && in_sop && hdr_dest == DROP)
      drop_cnt <= sat_inc(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_tlp_rw_demux.sv
// Randomized bench for tlp_rw_demux against a packet-level reference model.
// Define TLP_DEMUX_DROP_CNT_EN to also check the drop counter.
module tb_tlp_rw_demux;

  logic         clk;
  logic         rst_n;
  logic [255:0] in_data;
  logic [127:0] in_hdr;
  logic         in_sop, in_eop, in_valid, in_ready;
  logic [255:0] r_out_data, w_out_data;
  logic [127:0] r_out_hdr, w_out_hdr;
  logic         r_out_sop, r_out_eop, r_out_valid, r_out_ready;
  logic         w_out_sop, w_out_eop, w_out_valid, w_out_ready;
  logic         enable;
`ifdef TLP_DEMUX_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  tlp_rw_demux dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_hdr(in_hdr), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_out_data(r_out_data), .r_out_hdr(r_out_hdr), .r_out_sop(r_out_sop),
    .r_out_eop(r_out_eop), .r_out_valid(r_out_valid), .r_out_ready(r_out_ready),
    .w_out_data(w_out_data), .w_out_hdr(w_out_hdr), .w_out_sop(w_out_sop),
    .w_out_eop(w_out_eop), .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
`ifdef TLP_DEMUX_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .enable(enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one slot per output port, current packet destination, drop count.
  // Destinations: 0 none, 1 read, 2 write, 3 drop.
  logic         m_rv = 0, m_wv = 0, m_rsop = 0, m_reop = 0, m_wsop = 0, m_weop = 0;
  logic [255:0] m_rdata = '0, m_wdata = '0;
  logic [127:0] m_rhdr = '0, m_whdr = '0;
  logic         m_rst_seen = 1;
  int           m_cur = 0;
  int           m_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [127:0] h);
    int fmt, typ;
    fmt = int'(h[31:29]);
    typ = int'(h[28:24]);
    if (typ == 0 && fmt <= 1) return 1;
    if (typ == 0 && (fmt == 2 || fmt == 3)) return 2;
    return 3;
  endfunction

  function automatic logic [127:0] make_hdr(input int kind);
    logic [127:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    case (kind)
      0:       h[31:24] = {2'b00, 1'($urandom_range(0, 1)), 5'b00000};
      1:       h[31:24] = {2'b01, 1'($urandom_range(0, 1)), 5'b00000};
      2:       h[31:24] = 8'h04;
      default: h[31:24] = 8'($urandom);
    endcase
    return h;
  endfunction

  // One clock: check outputs, drive inputs, check in_ready, advance the model.
  task automatic step(input logic rst, input logic en, input logic vld, input logic sop,
                      input logic eop, input logic [127:0] hdr, input logic [255:0] data,
                      input logic rr, input logic wr, output logic acc);
    int   d;
    logic exp_rdy;
    @(negedge clk);
    chk("r_valid", 256'(r_out_valid), 256'(m_rv));
    chk("w_valid", 256'(w_out_valid), 256'(m_wv));
    if (m_rv || m_rst_seen) begin
      chk("r_data", r_out_data, m_rdata);
      chk("r_hdr", 256'(r_out_hdr), 256'(m_rhdr));
      chk("r_sop_eop", 256'({r_out_sop, r_out_eop}), 256'({m_rsop, m_reop}));
    end
    if (m_wv || m_rst_seen) begin
      chk("w_data", w_out_data, m_wdata);
      chk("w_hdr", 256'(w_out_hdr), 256'(m_whdr));
      chk("w_sop_eop", 256'({w_out_sop, w_out_eop}), 256'({m_wsop, m_weop}));
    end
`ifdef TLP_DEMUX_DROP_CNT_EN
    chk("drop_cnt", 256'(drop_cnt), 256'(m_cnt));
`endif
    rst_n = rst; enable = en; in_valid = vld; in_sop = sop; in_eop = eop;
    in_hdr = hdr; in_data = data; r_out_ready = rr; w_out_ready = wr;
    #1;
    d = sop ? classify(hdr) : (m_cur == 0 ? 3 : m_cur);
    exp_rdy = !rst && en && (d == 1 ? (!m_rv || rr) : d == 2 ? (!m_wv || wr) : 1'b1);
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    acc = vld && exp_rdy;
    if (rst) begin
      m_rv = 0; m_wv = 0; m_rsop = 0; m_reop = 0; m_wsop = 0; m_weop = 0;
      m_rdata = '0; m_wdata = '0; m_rhdr = '0; m_whdr = '0;
      m_cur = 0; m_cnt = 0; m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      if (m_rv && rr) m_rv = 0;
      if (m_wv && wr) m_wv = 0;
      if (acc && d == 1) begin
        m_rv = 1; m_rdata = data; m_rhdr = hdr; m_rsop = sop; m_reop = eop;
      end
      if (acc && d == 2) begin
        m_wv = 1; m_wdata = data; m_whdr = hdr; m_wsop = sop; m_weop = eop;
      end
      if (acc) begin
        if (eop) m_cur = 0;
        else if (sop) m_cur = classify(hdr);
        if (sop && classify(hdr) == 3 && m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  logic [127:0] h;
  logic         a;

  initial begin
    rst_n = 1; enable = 0; in_valid = 0; in_sop = 0; in_eop = 0;
    in_hdr = '0; in_data = '0; r_out_ready = 0; w_out_ready = 0;

    // Reset state
    repeat (3) step(1, 1, 1, 1, 1, make_hdr(0), 256'd7, 1, 1, a);

    // MRd single beat
    h = make_hdr(0);
    h[31:24] = 8'h00;
    step(0, 1, 1, 1, 1, h, 256'hA5, 1, 1, a);
    repeat (2) step(0, 1, 0, 0, 0, '0, '0, 1, 1, a);

    // MWr three beats
    h = make_hdr(1);
    h[31:24] = 8'h40;
    step(0, 1, 1, 1, 0, h, 256'd1, 1, 1, a);
    step(0, 1, 1, 0, 0, h, 256'd2, 1, 1, a);
    step(0, 1, 1, 0, 1, h, 256'd3, 1, 1, a);
    repeat (2) step(0, 1, 0, 0, 0, '0, '0, 1, 1, a);

    // CfgRd two beats, dropped
    h = make_hdr(2);
    step(0, 1, 1, 1, 0, h, 256'd11, 1, 1, a);
    step(0, 1, 1, 0, 1, h, 256'd12, 1, 1, a);

    // MRd with read sink stalled 10 cycles
    h = make_hdr(0);
    step(0, 1, 1, 1, 0, h, 256'd21, 0, 1, a);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1, h, 256'd22, 0, 1, a);
    a = 0;
    for (int i = 0; i < 4 && !a; i++) step(0, 1, 1, 0, 1, h, 256'd22, 1, 1, a);
    repeat (2) step(0, 1, 0, 0, 0, '0, '0, 1, 1, a);

    // Read port stalled while an MWr passes through
    step(0, 1, 1, 1, 1, make_hdr(0), 256'd31, 0, 1, a);
    h = make_hdr(1);
    step(0, 1, 1, 1, 0, h, 256'd32, 0, 1, a);
    step(0, 1, 1, 0, 1, h, 256'd33, 0, 1, a);
    repeat (2) step(0, 1, 0, 0, 0, '0, '0, 1, 1, a);

    // enable low mid-packet, then reset mid-packet
    h = make_hdr(1);
    step(0, 1, 1, 1, 0, h, 256'd41, 1, 1, a);
    repeat (2) step(0, 0, 1, 0, 0, h, 256'd42, 1, 1, a);
    step(0, 1, 1, 0, 0, h, 256'd42, 1, 1, a);
    step(1, 1, 1, 0, 0, h, 256'd43, 1, 1, a);
    step(0, 1, 1, 0, 1, h, 256'd44, 1, 1, a);
    step(0, 1, 0, 0, 0, '0, '0, 1, 1, a);

    // Randomized packet traffic
    begin
      int           left, pr, pw;
      logic         have, s, e, v;
      logic [127:0] ph;
      logic [255:0] pd;
      left = 0; have = 0; pr = 80; pw = 80;
      s = 0; e = 0; ph = '0; pd = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        logic rst, en, rr, wr;
        if (cyc % 64 == 0) begin
          pr = $urandom_range(5, 100);
          pw = $urandom_range(5, 100);
        end
        if (!have) begin
          if (left == 0 || $urandom_range(0, 99) < 3) begin
            if (left == 0 && $urandom_range(0, 99) < 4) begin
              s = 0; left = 1;
            end else begin
              s = 1; ph = make_hdr($urandom_range(0, 3)); left = $urandom_range(1, 4);
            end
          end else begin
            s = 0;
          end
          e = (left == 1);
          pd = {8{$urandom}};
          have = 1;
        end
        rst = ($urandom_range(0, 499) == 0);
        en  = ($urandom_range(0, 99) < 90);
        v   = ($urandom_range(0, 99) < 85);
        rr  = ($urandom_range(1, 100) <= pr);
        wr  = ($urandom_range(1, 100) <= pw);
        step(rst, en, v, s, e, ph, pd, rr, wr, a);
        if (rst) begin
          have = 0; left = 0;
        end else if (a) begin
          have = 0; left--;
        end
      end
    end
    repeat (3) step(0, 1, 0, 0, 0, '0, '0, 1, 1, a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
